// File: rtl/pathfinding_pkg.sv
// Shared types for the shortest-path search engine: vertex/distance words,
// queue opcodes, graph memory word layouts and the scheduler state encoding.
package pathfinding_pkg;

  typedef logic [15:0] vertex_t;
  typedef logic [15:0] dist_t;

  localparam dist_t INF_DIST = 16'hFFFF;
  localparam logic  PQ_PUSH  = 1'b1;
  localparam logic  PQ_POP   = 1'b0;

  typedef struct packed {
    vertex_t neighbor;
    dist_t   weight;
  } edge_t;

  typedef struct packed {
    logic [15:0] first_edge;
    logic [15:0] edge_count;
  } row_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DRAIN,
    S_CLEAR,
    S_SEED,
    S_POP_REQ,
    S_POP_WAIT,
    S_CHECK,
    S_ROW_RD,
    S_ROW_WAIT,
    S_EDGE_RD,
    S_EDGE_WAIT,
    S_RELAX,
    S_PUSH_REQ,
    S_PUSH_WAIT,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/dist_table.sv
// Per-vertex search state {dist, prev, visited}: one write port, a per-entry
// clear, and two combinational read ports (scheduler and host result).
import pathfinding_pkg::*;

module dist_table #(
  parameter int NUM_VERTICES = 64
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clr_en,
  input  vertex_t clr_addr,
  input  logic    wr_en,
  input  vertex_t wr_addr,
  input  dist_t   wr_dist,
  input  vertex_t wr_prev,
  input  logic    wr_visited,
  input  vertex_t rd_addr,
  output dist_t   rd_dist,
  output vertex_t rd_prev,
  output logic    rd_visited,
  input  vertex_t res_addr,
  output dist_t   res_dist,
  output vertex_t res_prev
);

  localparam int      AW = (NUM_VERTICES > 1) ? $clog2(NUM_VERTICES) : 1;
  localparam vertex_t NV = vertex_t'(NUM_VERTICES);

  dist_t                   dist_q    [NUM_VERTICES];
  vertex_t                 prev_q    [NUM_VERTICES];
  logic [NUM_VERTICES-1:0] visited_q;

  logic [AW-1:0] clr_idx;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] res_idx;

  assign clr_idx = clr_addr[AW-1:0];
  assign wr_idx  = wr_addr[AW-1:0];
  assign rd_idx  = rd_addr[AW-1:0];
  assign res_idx = res_addr[AW-1:0];

  // Clear wins over a normal write; out-of-range addresses are simply ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VERTICES; i++) begin
        dist_q[i] <= INF_DIST;
        prev_q[i] <= INF_DIST;
      end
      visited_q <= '0;
    end else if (clr_en && (clr_addr < NV)) begin
      dist_q[clr_idx]    <= INF_DIST;
      prev_q[clr_idx]    <= INF_DIST;
      visited_q[clr_idx] <= 1'b0;
    end else if (wr_en && (wr_addr < NV)) begin
      dist_q[wr_idx]    <= wr_dist;
      prev_q[wr_idx]    <= wr_prev;
      visited_q[wr_idx] <= wr_visited;
    end
  end

  always_comb begin
    rd_dist    = INF_DIST;
    rd_prev    = INF_DIST;
    rd_visited = 1'b0;
    if (rd_addr < NV) begin
      rd_dist    = dist_q[rd_idx];
      rd_prev    = prev_q[rd_idx];
      rd_visited = visited_q[rd_idx];
    end
  end

  always_comb begin
    res_dist = INF_DIST;
    res_prev = INF_DIST;
    if (res_addr < NV) begin
      res_dist = dist_q[res_idx];
      res_prev = prev_q[res_idx];
    end
  end

endmodule

// File: rtl/dijkstra_search_scheduler.sv
// Runs one single-source shortest-path search: drives the priority queue,
// walks adjacency rows and relaxes the distance table until dst or empty queue.
import pathfinding_pkg::*;

module dijkstra_search_scheduler #(
  parameter int NUM_VERTICES = 64,
  parameter int PQ_DEPTH     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] src_vertex,
  input  logic [15:0] dst_vertex,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [15:0] path_dist,
  output logic        err_overflow,
  output logic        err_bad_edge,
  output logic [15:0] row_addr,
  input  logic [31:0] row_rdata,
  output logic [15:0] adj_addr,
  input  logic [31:0] adj_rdata,
  output logic        pq_op_en,
  output logic        pq_opcode,
  output logic [15:0] pq_in_vertex,
  output logic [15:0] pq_in_prev_vertex,
  output logic [15:0] pq_dist,
  input  logic        pq_done,
  input  logic [15:0] pq_length,
  input  logic [15:0] pq_pop_vertex,
  input  logic [15:0] pq_pop_prev,
  input  logic [15:0] pq_pop_dist,
  input  logic [15:0] res_vertex,
  output logic [15:0] res_dist,
  output logic [15:0] res_prev
);

  localparam vertex_t     NV    = vertex_t'(NUM_VERTICES);
  localparam logic [15:0] DEPTH = 16'(PQ_DEPTH);

  sched_state_e state;
  logic         pq_wait;
  vertex_t      src_q, dst_q, clr_idx;
  vertex_t      cur_vertex, nbr_q;
  dist_t        cur_dist, weight_q;
  logic [15:0]  edge_rem;

  row_t  row;
  edge_t edge_w;
  assign row    = row_t'(row_rdata);
  assign edge_w = edge_t'(adj_rdata);

  // The popped entry's prev is not needed: the table already holds the best prev.
  logic unused_pop_prev;
  assign unused_pop_prev = ^pq_pop_prev;

  vertex_t tbl_rd_addr, tbl_wr_addr, tbl_wr_prev, tbl_rd_prev;
  dist_t   tbl_wr_dist, tbl_rd_dist;
  logic    tbl_wr_en, tbl_wr_visited, tbl_rd_visited;

  logic [16:0] sum;
  logic        nbr_ok, relax_ok, last_edge;

  assign sum       = {1'b0, cur_dist} + {1'b0, weight_q};
  assign nbr_ok    = nbr_q < NV;
  assign relax_ok  = nbr_ok && !tbl_rd_visited && (sum < 17'h0FFFF) && (sum[15:0] < tbl_rd_dist);
  assign last_edge = edge_rem == 16'd1;

  dist_table #(.NUM_VERTICES(NUM_VERTICES)) u_table (
    .clk        (clk),
    .reset      (reset),
    .clr_en     (state == S_CLEAR),
    .clr_addr   (clr_idx),
    .wr_en      (tbl_wr_en),
    .wr_addr    (tbl_wr_addr),
    .wr_dist    (tbl_wr_dist),
    .wr_prev    (tbl_wr_prev),
    .wr_visited (tbl_wr_visited),
    .rd_addr    (tbl_rd_addr),
    .rd_dist    (tbl_rd_dist),
    .rd_prev    (tbl_rd_prev),
    .rd_visited (tbl_rd_visited),
    .res_addr   (res_vertex),
    .res_dist   (res_dist),
    .res_prev   (res_prev)
  );

  // Table writes: seed the source, mark the expanded vertex, record relaxations.
  always_comb begin
    tbl_rd_addr    = (state == S_RELAX) ? nbr_q : cur_vertex;
    tbl_wr_en      = 1'b0;
    tbl_wr_addr    = cur_vertex;
    tbl_wr_dist    = tbl_rd_dist;
    tbl_wr_prev    = tbl_rd_prev;
    tbl_wr_visited = 1'b0;
    case (state)
      S_SEED: if (!pq_wait) begin
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = src_q;
        tbl_wr_dist = '0;
        tbl_wr_prev = INF_DIST;
      end
      S_CHECK: if (!tbl_rd_visited && (cur_vertex != dst_q)) begin
        tbl_wr_en      = 1'b1;
        tbl_wr_visited = 1'b1;
      end
      S_RELAX: if (relax_ok) begin
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = nbr_q;
        tbl_wr_dist = sum[15:0];
        tbl_wr_prev = cur_vertex;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      pq_wait           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      found             <= 1'b0;
      path_dist         <= INF_DIST;
      err_overflow      <= 1'b0;
      err_bad_edge      <= 1'b0;
      row_addr          <= '0;
      adj_addr          <= '0;
      pq_op_en          <= 1'b0;
      pq_opcode         <= 1'b0;
      pq_in_vertex      <= '0;
      pq_in_prev_vertex <= '0;
      pq_dist           <= '0;
      src_q             <= '0;
      dst_q             <= '0;
      clr_idx           <= '0;
      cur_vertex        <= '0;
      cur_dist          <= '0;
      nbr_q             <= '0;
      weight_q          <= '0;
      edge_rem          <= '0;
    end else begin
      done     <= 1'b0;
      pq_op_en <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          src_q        <= src_vertex;
          dst_q        <= dst_vertex;
          found        <= 1'b0;
          path_dist    <= INF_DIST;
          err_overflow <= 1'b0;
          pq_wait      <= 1'b0;
          clr_idx      <= '0;
          if ((src_vertex >= NV) || (dst_vertex >= NV)) begin
            err_bad_edge <= 1'b1;
            done         <= 1'b1;
            state        <= S_DONE;
          end else begin
            err_bad_edge <= 1'b0;
            busy         <= 1'b1;
            state        <= S_DRAIN;
          end
        end
        // Leftovers from an earlier search are popped and discarded.
        S_DRAIN: begin
          if (pq_wait) begin
            if (pq_done) pq_wait <= 1'b0;
          end else if (pq_length == 16'd0) begin
            state <= S_CLEAR;
          end else begin
            pq_op_en  <= 1'b1;
            pq_opcode <= PQ_POP;
            pq_wait   <= 1'b1;
          end
        end
        S_CLEAR: begin
          clr_idx <= clr_idx + 16'd1;
          if (clr_idx == NV - 16'd1) state <= S_SEED;
        end
        S_SEED: begin
          if (!pq_wait) begin
            pq_op_en          <= 1'b1;
            pq_opcode         <= PQ_PUSH;
            pq_in_vertex      <= src_q;
            pq_in_prev_vertex <= src_q;
            pq_dist           <= '0;
            pq_wait           <= 1'b1;
          end else if (pq_done) begin
            pq_wait <= 1'b0;
            state   <= S_POP_REQ;
          end
        end
        S_POP_REQ: begin
          if (pq_length == 16'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            pq_op_en  <= 1'b1;
            pq_opcode <= PQ_POP;
            state     <= S_POP_WAIT;
          end
        end
        S_POP_WAIT: if (pq_done) begin
          cur_vertex <= pq_pop_vertex;
          cur_dist   <= pq_pop_dist;
          state      <= S_CHECK;
        end
        // Visited vertices mark stale queue entries (lazy deletion).
        S_CHECK: begin
          if (tbl_rd_visited) begin
            state <= S_POP_REQ;
          end else if (cur_vertex == dst_q) begin
            found     <= 1'b1;
            path_dist <= cur_dist;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            row_addr <= cur_vertex;
            state    <= S_ROW_RD;
          end
        end
        S_ROW_RD: state <= S_ROW_WAIT;
        S_ROW_WAIT: begin
          if (row.edge_count == 16'd0) begin
            state <= S_POP_REQ;
          end else begin
            adj_addr <= row.first_edge;
            edge_rem <= row.edge_count;
            state    <= S_EDGE_RD;
          end
        end
        S_EDGE_RD: state <= S_EDGE_WAIT;
        S_EDGE_WAIT: begin
          nbr_q    <= edge_w.neighbor;
          weight_q <= edge_w.weight;
          state    <= S_RELAX;
        end
        S_RELAX: begin
          if (!nbr_ok) err_bad_edge <= 1'b1;
          if (relax_ok) begin
            pq_in_vertex      <= nbr_q;
            pq_in_prev_vertex <= cur_vertex;
            pq_dist           <= sum[15:0];
            state             <= S_PUSH_REQ;
          end else if (last_edge) begin
            state <= S_POP_REQ;
          end else begin
            edge_rem <= edge_rem - 16'd1;
            adj_addr <= adj_addr + 16'd1;
            state    <= S_EDGE_RD;
          end
        end
        // A full queue drops the push; the table update already stands.
        S_PUSH_REQ: begin
          if (pq_length >= DEPTH) begin
            err_overflow <= 1'b1;
            if (last_edge) begin
              state <= S_POP_REQ;
            end else begin
              edge_rem <= edge_rem - 16'd1;
              adj_addr <= adj_addr + 16'd1;
              state    <= S_EDGE_RD;
            end
          end else begin
            pq_op_en  <= 1'b1;
            pq_opcode <= PQ_PUSH;
            state     <= S_PUSH_WAIT;
          end
        end
        S_PUSH_WAIT: if (pq_done) begin
          if (last_edge) begin
            state <= S_POP_REQ;
          end else begin
            edge_rem <= edge_rem - 16'd1;
            adj_addr <= adj_addr + 16'd1;
            state    <= S_EDGE_RD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dijkstra_search_scheduler.sv
// Directed bench: behavioural min-queue stub plus small graph memories around the scheduler.
module tb_dijkstra_search_scheduler;
  import pathfinding_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_vertex, dst_vertex;
  logic        busy, done, found, err_overflow, err_bad_edge;
  logic [15:0] path_dist, row_addr, adj_addr;
  logic [31:0] row_rdata, adj_rdata;
  logic        pq_op_en, pq_opcode, pq_done;
  logic [15:0] pq_in_vertex, pq_in_prev_vertex, pq_dist, pq_length;
  logic [15:0] pq_pop_vertex, pq_pop_prev, pq_pop_dist;
  logic [15:0] res_vertex, res_dist, res_prev;

  int checks = 0;
  int errors = 0;
  int push_count = 0;
  int pop_count = 0;

  logic [31:0] row_mem [16];
  logic [31:0] adj_mem [32];

  vertex_t qv [64];
  vertex_t qp [64];
  dist_t   qd [64];
  int      q_n;
  int      lat;

  always #5 clk = ~clk;

  dijkstra_search_scheduler #(.NUM_VERTICES(16), .PQ_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_vertex(src_vertex), .dst_vertex(dst_vertex),
    .busy(busy), .done(done), .found(found), .path_dist(path_dist),
    .err_overflow(err_overflow), .err_bad_edge(err_bad_edge),
    .row_addr(row_addr), .row_rdata(row_rdata),
    .adj_addr(adj_addr), .adj_rdata(adj_rdata),
    .pq_op_en(pq_op_en), .pq_opcode(pq_opcode),
    .pq_in_vertex(pq_in_vertex), .pq_in_prev_vertex(pq_in_prev_vertex), .pq_dist(pq_dist),
    .pq_done(pq_done), .pq_length(pq_length),
    .pq_pop_vertex(pq_pop_vertex), .pq_pop_prev(pq_pop_prev), .pq_pop_dist(pq_pop_dist),
    .res_vertex(res_vertex), .res_dist(res_dist), .res_prev(res_prev)
  );

  // Graph memories with one-cycle synchronous read
  always @(posedge clk) begin
    row_rdata <= (row_addr < 16'd16) ? row_mem[row_addr[3:0]] : 32'h0;
    adj_rdata <= (adj_addr < 16'd32) ? adj_mem[adj_addr[4:0]] : 32'h0;
  end

  // Queue stub: min-dist pop (oldest wins ties), pq_done two cycles after request
  always @(posedge clk) begin : pq_stub
    int m;
    if (reset) begin
      q_n = 0;
      lat <= 0;
      pq_done <= 1'b0;
      pq_length <= 16'd0;
      pq_pop_vertex <= 16'd0;
      pq_pop_prev <= 16'd0;
      pq_pop_dist <= 16'd0;
    end else begin
      pq_done <= (lat == 1);
      if (lat != 0) lat <= lat - 1;
      if (pq_op_en) begin
        if (lat != 0) begin
          errors++;
          $display("[TB] FAIL queue_protocol request while busy, lat=%0d want 0", lat);
        end
        if (pq_opcode == PQ_PUSH) begin
          if (q_n < 64) begin
            qv[q_n] = pq_in_vertex;
            qp[q_n] = pq_in_prev_vertex;
            qd[q_n] = pq_dist;
            q_n++;
          end
          push_count++;
        end else begin
          if (q_n > 0) begin
            m = 0;
            for (int i = 1; i < q_n; i++) if (qd[i] < qd[m]) m = i;
            pq_pop_vertex <= qv[m];
            pq_pop_prev <= qp[m];
            pq_pop_dist <= qd[m];
            for (int i = m; i < q_n - 1; i++) begin
              qv[i] = qv[i+1];
              qp[i] = qp[i+1];
              qd[i] = qd[i+1];
            end
            q_n--;
          end
          pop_count++;
        end
        pq_length <= 16'(q_n);
        lat <= 2;
      end
    end
  end

  task clear_graph;
    for (int i = 0; i < 16; i++) row_mem[i] = 32'h0;
    for (int i = 0; i < 32; i++) adj_mem[i] = 32'h0;
  endtask

  task set_row(input int v, input int first, input int cnt);
    row_mem[v] = {16'(first), 16'(cnt)};
  endtask

  task set_edge(input int idx, input int nbr, input int w);
    adj_mem[idx] = {16'(nbr), 16'(w)};
  endtask

  task load_line;
    clear_graph();
    set_row(0, 0, 1); set_edge(0, 1, 3);
    set_row(1, 1, 1); set_edge(1, 2, 4);
    set_row(2, 2, 1); set_edge(2, 3, 5);
  endtask

  task run_search(input int s, input int d, output logic busy_seen);
    logic ok;
    @(negedge clk);
    src_vertex = 16'(s);
    dst_vertex = 16'(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_seen = busy;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL search_timeout src=%0d dst=%0d done never seen, want done within 5000 cycles", s, d);
    end
  endtask

  task test_reset;
    reset = 1'b1;
    start = 1'b0;
    src_vertex = 16'd0;
    dst_vertex = 16'd0;
    res_vertex = 16'd0;
    clear_graph();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, found, err_overflow, err_bad_edge, pq_op_en, pq_opcode} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 0000000", {busy, done, found, err_overflow, err_bad_edge, pq_op_en, pq_opcode});
    end
    checks++;
    if (path_dist !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL reset_path_dist got %h want ffff", path_dist);
    end
    checks++;
    if ({row_addr, adj_addr, pq_in_vertex, pq_in_prev_vertex, pq_dist} !== 80'h0) begin
      errors++;
      $display("[TB] FAIL reset_addr_payload got %h want 0", {row_addr, adj_addr, pq_in_vertex, pq_in_prev_vertex, pq_dist});
    end
    checks++;
    if (res_dist !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL reset_res_dist got %h want ffff", res_dist);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task test_line;
    logic b;
    load_line();
    run_search(0, 3, b);
    checks++;
    if (b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL line_busy got %b want 1", b);
    end
    checks++;
    if (found !== 1'b1 || path_dist !== 16'd12) begin
      errors++;
      $display("[TB] FAIL line_result found=%b dist=%0d want found=1 dist=12", found, path_dist);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL line_busy_at_done got %b want 0", busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || found !== 1'b1 || path_dist !== 16'd12) begin
      errors++;
      $display("[TB] FAIL line_hold done=%b found=%b dist=%0d want 0 1 12", done, found, path_dist);
    end
    res_vertex = 16'd3;
    #1;
    checks++;
    if (res_prev !== 16'd2 || res_dist !== 16'd12) begin
      errors++;
      $display("[TB] FAIL line_res3 prev=%0d dist=%0d want prev=2 dist=12", res_prev, res_dist);
    end
    res_vertex = 16'd1;
    #1;
    checks++;
    if (res_prev !== 16'd0 || res_dist !== 16'd3) begin
      errors++;
      $display("[TB] FAIL line_res1 prev=%0d dist=%0d want prev=0 dist=3", res_prev, res_dist);
    end
  endtask

  task load_diamond;
    clear_graph();
    set_row(0, 0, 2); set_edge(0, 1, 1); set_edge(1, 2, 5);
    set_row(1, 2, 1); set_edge(2, 2, 1);
    set_row(2, 3, 1); set_edge(3, 3, 1);
  endtask

  task test_diamond;
    logic b;
    load_diamond();
    run_search(0, 3, b);
    checks++;
    if (found !== 1'b1 || path_dist !== 16'd3) begin
      errors++;
      $display("[TB] FAIL diamond_result found=%b dist=%0d want found=1 dist=3", found, path_dist);
    end
    res_vertex = 16'd2;
    #1;
    checks++;
    if (res_prev !== 16'd1 || res_dist !== 16'd2) begin
      errors++;
      $display("[TB] FAIL diamond_res2 prev=%0d dist=%0d want prev=1 dist=2", res_prev, res_dist);
    end
  endtask

  // Diamond again with an isolated target: the stale {2,5} entry is drained by the search
  task test_unreachable;
    logic b;
    int pops0, pushes0;
    pops0 = pop_count;
    pushes0 = push_count;
    run_search(0, 4, b);
    checks++;
    if (found !== 1'b0 || path_dist !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL unreach_result found=%b dist=%h want found=0 dist=ffff", found, path_dist);
    end
    checks++;
    if (pop_count - pops0 != 6 || push_count - pushes0 != 5) begin
      errors++;
      $display("[TB] FAIL unreach_queue_ops pops=%0d pushes=%0d want pops=6 pushes=5", pop_count - pops0, push_count - pushes0);
    end
    res_vertex = 16'd3;
    #1;
    checks++;
    if (res_dist !== 16'd3) begin
      errors++;
      $display("[TB] FAIL unreach_res3 dist=%0d want 3", res_dist);
    end
  endtask

  task test_weight_limit;
    logic b;
    int pushes0;
    clear_graph();
    set_row(0, 0, 1); set_edge(0, 1, 16'h20);
    set_row(1, 1, 1); set_edge(1, 2, 16'hFFF0);
    pushes0 = push_count;
    run_search(0, 2, b);
    checks++;
    if (found !== 1'b0 || path_dist !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL weight_result found=%b dist=%h want found=0 dist=ffff", found, path_dist);
    end
    checks++;
    if (push_count - pushes0 != 2) begin
      errors++;
      $display("[TB] FAIL weight_pushes got %0d want 2", push_count - pushes0);
    end
    res_vertex = 16'd2;
    #1;
    checks++;
    if (res_dist !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL weight_res2 dist=%h want ffff", res_dist);
    end
    res_vertex = 16'd1;
    #1;
    checks++;
    if (res_dist !== 16'h0020) begin
      errors++;
      $display("[TB] FAIL weight_res1 dist=%h want 0020", res_dist);
    end
  endtask

  // Star of 4 edges plus one out-of-range neighbor against a depth-2 queue
  task test_overflow;
    logic b;
    int pushes0;
    clear_graph();
    set_row(0, 0, 5);
    set_edge(0, 1, 1); set_edge(1, 2, 2); set_edge(2, 3, 3); set_edge(3, 4, 4);
    set_edge(4, 30, 1);
    pushes0 = push_count;
    run_search(0, 5, b);
    checks++;
    if (err_overflow !== 1'b1 || err_bad_edge !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_errs ovf=%b bad=%b want 1 1", err_overflow, err_bad_edge);
    end
    checks++;
    if (found !== 1'b0 || push_count - pushes0 != 3) begin
      errors++;
      $display("[TB] FAIL overflow_result found=%b pushes=%0d want found=0 pushes=3", found, push_count - pushes0);
    end
    res_vertex = 16'd4;
    #1;
    checks++;
    if (res_dist !== 16'd4 || res_prev !== 16'd0) begin
      errors++;
      $display("[TB] FAIL overflow_res4 dist=%0d prev=%0d want dist=4 prev=0", res_dist, res_prev);
    end
  endtask

  task test_src_eq_dst;
    logic b;
    run_search(2, 2, b);
    checks++;
    if (found !== 1'b1 || path_dist !== 16'd0) begin
      errors++;
      $display("[TB] FAIL self_result found=%b dist=%0d want found=1 dist=0", found, path_dist);
    end
    checks++;
    if (err_overflow !== 1'b0 || err_bad_edge !== 1'b0) begin
      errors++;
      $display("[TB] FAIL self_errs_cleared ovf=%b bad=%b want 0 0", err_overflow, err_bad_edge);
    end
  endtask

  task test_bad_source;
    logic b;
    int pops0;
    pops0 = pop_count;
    run_search(20, 1, b);
    checks++;
    if (found !== 1'b0 || path_dist !== 16'hFFFF || err_bad_edge !== 1'b1) begin
      errors++;
      $display("[TB] FAIL badsrc_result found=%b dist=%h bad=%b want 0 ffff 1", found, path_dist, err_bad_edge);
    end
    checks++;
    if (pop_count != pops0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL badsrc_no_queue pops=%0d busy=%b want pops=0 busy=0", pop_count - pops0, busy);
    end
  endtask

  task test_reset_mid_search;
    logic b;
    logic hit;
    load_line();
    @(negedge clk);
    src_vertex = 16'd0;
    dst_vertex = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (dut.state == S_RELAX) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL midreset_reach_relax not reached, want RELAX within 2000 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pq_op_en !== 1'b0 || dut.state != S_IDLE) begin
      errors++;
      $display("[TB] FAIL midreset_idle busy=%b op_en=%b state=%0d want 0 0 IDLE", busy, pq_op_en, dut.state);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pq_op_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet busy=%b op_en=%b want 0 0", busy, pq_op_en);
    end
    run_search(0, 3, b);
    checks++;
    if (found !== 1'b1 || path_dist !== 16'd12) begin
      errors++;
      $display("[TB] FAIL midreset_rerun found=%b dist=%0d want found=1 dist=12", found, path_dist);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_diamond();
    test_unreachable();
    test_weight_limit();
    test_overflow();
    test_src_eq_dst();
    test_bad_source();
    test_reset_mid_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
